// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings, FSM state type and op-decode helpers for the LSU.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Encodings with no defined access; stores have no unsigned variants.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  // Size comes from funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (f3[1:0] == 2'b01) mis = a[0];
    if (f3[1:0] == 2'b10) mis = (a != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus bundle for the LSU.
interface load_store_unit_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [2:0]  req_funct3_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        dmem_valid_out;
  logic        dmem_we_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_ack_in;
  logic        dmem_err_in;
  logic [31:0] dmem_rdata_in;
  logic        resp_valid_out;
  logic [31:0] load_output_out;
  logic        misaligned_out;
  logic        fault_out;
  logic        stall_out;

  modport slave (
    input  req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in,
    input  dmem_ack_in, dmem_err_in, dmem_rdata_in,
    output req_ready_out, dmem_valid_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    output dmem_be_out, resp_valid_out, load_output_out, misaligned_out, fault_out,
    output stall_out
  );

  modport master (
    output req_valid_in, req_we_in, req_funct3_in, req_addr_in, req_wdata_in,
    output dmem_ack_in, dmem_err_in, dmem_rdata_in,
    input  req_ready_out, dmem_valid_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
    input  dmem_be_out, resp_valid_out, load_output_out, misaligned_out, fault_out,
    input  stall_out
  );
endinterface

// File: rtl/load_store_unit_data_align.sv
// Store lane replication / byte enables and load extract / extension.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);
  logic [31:0] shifted;

  // Byte enables follow the access size for loads too, so the bus sees the touched lanes.
  always_comb begin
    shifted    = rdata_i >> {addr_lo_i, 3'b000};
    st_wdata_o = wdata_i;
    st_be_o    = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        st_wdata_o = {4{wdata_i[7:0]}};
        st_be_o    = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        st_wdata_o = {2{wdata_i[15:0]}};
        st_be_o    = 4'b0011 << addr_lo_i;
      end
      default: ;
    endcase
    case (funct3_i)
      F3_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ld_data_o = {24'd0, shifted[7:0]};
      F3_LHU:  ld_data_o = {16'd0, shifted[15:0]};
      default: ld_data_o = shifted;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// LSU top: request FSM, bus capture registers, timeout counter and response registers.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk_in,
  input logic               rst_in,
  load_store_unit_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  be_q;
  logic        mis_q, fault_q;

  logic        accept, illegal, mis, timeout_hit;
  logic [2:0]  al_f3;
  logic [1:0]  al_alo;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_be;

  assign accept      = bus.req_valid_in && bus.req_ready_out;
  assign illegal     = is_illegal(bus.req_we_in, bus.req_funct3_in);
  assign mis         = !illegal && is_misaligned(bus.req_funct3_in, bus.req_addr_in[1:0]);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  // Outside REQ the aligner serves the incoming store; in REQ it extracts the captured load.
  assign al_f3       = (state_q == REQ) ? f3_q  : bus.req_funct3_in;
  assign al_alo      = (state_q == REQ) ? alo_q : bus.req_addr_in[1:0];

  lsu_data_align u_align (
    .funct3_i  (al_f3),
    .addr_lo_i (al_alo),
    .wdata_i   (bus.req_wdata_in),
    .rdata_i   (bus.dmem_rdata_in),
    .st_wdata_o(st_wdata),
    .st_be_o   (st_be),
    .ld_data_o (ld_data)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; bad ops skip the bus and answer directly
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept)              state_d = (illegal || mis) ? RESP : REQ;
        else if (state_q == RESP) state_d = IDLE;
      end
      REQ:     if (bus.dmem_err_in || bus.dmem_ack_in || timeout_hit) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state plus the capture/response registers
  always_comb begin
    bus.req_ready_out   = (state_q == IDLE) || (state_q == RESP);
    bus.dmem_valid_out  = (state_q == REQ);
    bus.stall_out       = (state_q == REQ);
    bus.resp_valid_out  = (state_q == RESP);
    bus.dmem_we_out     = we_q;
    bus.dmem_addr_out   = addr_q;
    bus.dmem_wdata_out  = wdata_q;
    bus.dmem_be_out     = be_q;
    bus.load_output_out = load_q;
    bus.misaligned_out  = mis_q;
    bus.fault_out       = fault_q;
  end

  // Capture the op on accept, count REQ cycles, register the completion result
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      alo_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      load_q  <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        if (illegal || mis) begin
          load_q  <= '0;
          mis_q   <= mis;
          fault_q <= illegal;
        end else begin
          cnt_q   <= '0;
          we_q    <= bus.req_we_in;
          f3_q    <= bus.req_funct3_in;
          alo_q   <= bus.req_addr_in[1:0];
          addr_q  <= {bus.req_addr_in[31:2], 2'b00};
          wdata_q <= st_wdata;
          be_q    <= st_be;
        end
      end
      if (state_q == REQ) begin
        cnt_q <= cnt_q + CW'(1);
        mis_q <= 1'b0;
        if (bus.dmem_err_in) begin
          load_q  <= '0;
          fault_q <= 1'b1;
        end else if (bus.dmem_ack_in) begin
          load_q  <= we_q ? 32'd0 : ld_data;
          fault_q <= 1'b0;
        end else if (timeout_hit) begin
          load_q  <= '0;
          fault_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  load_store_unit_if lif ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (lif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, legality, lanes and extended load value.
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_illegal(input bit we, input logic [2:0] f3);
    return (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint sz, v;
    sz = op_size(f3);
    v  = longint'(rdata) / (longint'(1) << (8 * (addr % 4)));
    v  = v % (longint'(1) << (8 * sz));
    if (f3 < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = op_size(f3);
    if (sz == 1) return wd[7:0] * 32'h0101_0101;
    if (sz == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int t;
    t = ((1 << op_size(f3)) - 1) << (addr % 4);
    return t[3:0];
  endfunction

  // One complete transaction, from presenting the request to the response cycle.
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_delay, input logic [31:0] rdata,
                       input bit err, input bit also_ack);
    bit ill, mis, to;
    ill = op_illegal(we, f3);
    mis = !ill && ((addr % op_size(f3)) != 0);
    lif.req_valid_in  = 1'b1;
    lif.req_we_in     = we;
    lif.req_funct3_in = f3;
    lif.req_addr_in   = addr;
    lif.req_wdata_in  = wdata;
    chk("ready_at_accept", lif.req_ready_out, 1'b1);
    tick;
    lif.req_valid_in = 1'b0;
    lif.req_addr_in  = $urandom;
    lif.req_wdata_in = $urandom;
    if (ill || mis) begin
      chk("bypass_dmem_valid", lif.dmem_valid_out, 1'b0);
      chk("bypass_resp_valid", lif.resp_valid_out, 1'b1);
      chk("bypass_misaligned", lif.misaligned_out, mis);
      chk("bypass_fault", lif.fault_out, ill);
      chk("bypass_load", lif.load_output_out, 32'd0);
    end else begin
      for (int i = 0; i < TO; i++) begin
        chk("req_dmem_valid", lif.dmem_valid_out, 1'b1);
        chk("req_dmem_addr", lif.dmem_addr_out, addr & 32'hFFFF_FFFC);
        chk("req_dmem_we", lif.dmem_we_out, we);
        chk("req_dmem_be", lif.dmem_be_out, model_be(f3, addr));
        if (we) chk("req_dmem_wdata", lif.dmem_wdata_out, model_wdata(f3, wdata));
        chk("req_stall", lif.stall_out, 1'b1);
        chk("req_ready", lif.req_ready_out, 1'b0);
        chk("req_no_resp", lif.resp_valid_out, 1'b0);
        if (i == ack_delay) begin
          lif.dmem_ack_in   = !err || also_ack;
          lif.dmem_err_in   = err;
          lif.dmem_rdata_in = rdata;
        end else begin
          lif.dmem_rdata_in = $urandom;
        end
        tick;
        lif.dmem_ack_in = 1'b0;
        lif.dmem_err_in = 1'b0;
        if (i == ack_delay) break;
      end
      to = (ack_delay >= TO);
      chk("resp_valid", lif.resp_valid_out, 1'b1);
      chk("resp_dmem_valid", lif.dmem_valid_out, 1'b0);
      chk("resp_stall", lif.stall_out, 1'b0);
      chk("resp_misaligned", lif.misaligned_out, 1'b0);
      chk("resp_fault", lif.fault_out, err || to);
      chk("resp_load", lif.load_output_out,
          (we || err || to) ? 32'd0 : model_load(f3, addr, rdata));
    end
  endtask

  task automatic idle_check(input string tag);
    tick;
    chk({tag, "_resp_low"}, lif.resp_valid_out, 1'b0);
    chk({tag, "_ready"}, lif.req_ready_out, 1'b1);
    chk({tag, "_dmem_low"}, lif.dmem_valid_out, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lif.req_valid_in  = 1'b0;
    lif.req_we_in     = 1'b0;
    lif.req_funct3_in = 3'b000;
    lif.req_addr_in   = '0;
    lif.req_wdata_in  = '0;
    lif.dmem_ack_in   = 1'b0;
    lif.dmem_err_in   = 1'b0;
    lif.dmem_rdata_in = '0;
    #3;
    chk("rst_ready", lif.req_ready_out, 1'b1);
    chk("rst_dmem_valid", lif.dmem_valid_out, 1'b0);
    chk("rst_dmem_addr", lif.dmem_addr_out, 32'd0);
    chk("rst_dmem_be", lif.dmem_be_out, 4'd0);
    chk("rst_dmem_we", lif.dmem_we_out, 1'b0);
    chk("rst_resp_valid", lif.resp_valid_out, 1'b0);
    chk("rst_load", lif.load_output_out, 32'd0);
    chk("rst_fault", lif.fault_out, 1'b0);
    chk("rst_stall", lif.stall_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // LW with the fastest ack
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("t1_load", lif.load_output_out, 32'hDEADBEEF);
    idle_check("t1_after");

    // Byte/half extraction and extension
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233, 1'b0, 1'b0);
    chk("t2_lb", lif.load_output_out, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233, 1'b0, 1'b0);
    chk("t2_lbu", lif.load_output_out, 32'h00000080);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80112233, 1'b0, 1'b0);
    chk("t2_lhu", lif.load_output_out, 32'h00008011);
    idle_check("t2_after");

    // SB lane replication
    lif.req_valid_in  = 1'b1;
    lif.req_we_in     = 1'b1;
    lif.req_funct3_in = 3'b000;
    lif.req_addr_in   = 32'h201;
    lif.req_wdata_in  = 32'h000000A5;
    tick;
    lif.req_valid_in = 1'b0;
    chk("t3_addr", lif.dmem_addr_out, 32'h200);
    chk("t3_wdata", lif.dmem_wdata_out, 32'hA5A5A5A5);
    chk("t3_be", lif.dmem_be_out, 4'b0010);
    chk("t3_we", lif.dmem_we_out, 1'b1);
    lif.dmem_ack_in = 1'b1;
    tick;
    lif.dmem_ack_in = 1'b0;
    chk("t3_resp", lif.resp_valid_out, 1'b1);
    chk("t3_load", lif.load_output_out, 32'd0);
    idle_check("t3_after");

    // Misaligned ops never reach the bus
    do_op(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    chk("t4_lh_mis", lif.misaligned_out, 1'b1);
    do_op(1'b1, 3'b010, 32'h102, 32'h12345678, 0, 32'h0, 1'b0, 1'b0);
    chk("t4_sw_mis", lif.misaligned_out, 1'b1);
    idle_check("t4_after");

    // Timeout after exactly TO REQ cycles, then err beating ack
    do_op(1'b0, 3'b010, 32'h300, 32'h0, 100, 32'h0, 1'b0, 1'b0);
    chk("t5_timeout_fault", lif.fault_out, 1'b1);
    idle_check("t5_after_to");
    do_op(1'b0, 3'b010, 32'h304, 32'h0, 1, 32'hCAFEF00D, 1'b1, 1'b1);
    chk("t5_err_ack_fault", lif.fault_out, 1'b1);
    idle_check("t5_after_err");

    // Stray ack/err while idle must be ignored
    lif.dmem_ack_in = 1'b1;
    lif.dmem_err_in = 1'b1;
    idle_check("stray_ack");
    lif.dmem_ack_in = 1'b0;
    lif.dmem_err_in = 1'b0;
    idle_check("stray_ack2");

    // Reset while REQ is outstanding
    lif.req_valid_in  = 1'b1;
    lif.req_we_in     = 1'b0;
    lif.req_funct3_in = 3'b010;
    lif.req_addr_in   = 32'h400;
    tick;
    lif.req_valid_in = 1'b0;
    chk("t6_req_active", lif.dmem_valid_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_dmem_drop", lif.dmem_valid_out, 1'b0);
    chk("t6_rst_ready", lif.req_ready_out, 1'b1);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) idle_check("t6_no_resp");

    // Randomized ops, often back-to-back from the response cycle
    for (int n = 0; n < 60; n++) begin
      bit          we, er;
      logic [2:0]  f3;
      logic [31:0] a;
      int          d;
      we = $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = {we ? 1'b0 : f3[2], f3[1] & ~f3[0], f3[0]};
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~(32'(op_size(f3)) - 32'd1);
      d  = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 2);
      er = ($urandom_range(0, 7) == 0);
      do_op(we, f3, a, $urandom, d, $urandom, er, $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) idle_check("rand_gap");
    end
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
